spi_reg_bridge: RTL and testbench

SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

---
 rtl/spi_reg_bridge.sv | 118 +++++++++++
 tb/tb_spi_reg_bridge.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// Register-file bridge behind an SPI slave: one command byte {rw, addr}, then a
// data byte for writes or a single response byte for reads, one per ss_n frame.

module spi_reg_cell (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [7:0] din,
  output logic [7:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= 8'h00;
    else if (we) q <= din;
  end
endmodule

module spi_reg_bridge #(
  parameter int         REG_COUNT = 8,
  parameter logic [7:0] ERR_BYTE  = 8'hEE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_done,
  input  logic                   ss_n,
  output logic [8*REG_COUNT-1:0] regs_flat,
  output logic                   wr_strobe,
  output logic [6:0]             wr_addr,
  output logic                   err
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WR_DATA = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;
  localparam logic [1:0] DRAIN   = 2'd3;
  localparam logic [7:0] RC      = 8'(REG_COUNT);

  logic [1:0]                  state;
  logic [6:0]                  addr;
  logic                        in_range;
  logic                        wr_hit;
  logic [7:0]                  rd_byte;
  logic [REG_COUNT-1:0][7:0]   regs;

  assign in_range  = ({1'b0, addr} < RC);
  // A data byte only commits if the frame is still open on that same edge.
  assign wr_hit    = (state == WR_DATA) && rx_valid && !ss_n && in_range;
  assign regs_flat = regs;

  genvar g;
  generate
    for (g = 0; g < REG_COUNT; g++) begin : g_reg
      spi_reg_cell u_cell (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (wr_hit && (addr == 7'(g))),
        .din  (rx_data),
        .q    (regs[g])
      );
    end
  endgenerate

  always_comb begin
    rd_byte = ERR_BYTE;
    for (int i = 0; i < REG_COUNT; i++)
      if (addr == 7'(i)) rd_byte = regs[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= 7'd0;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 7'd0;
      err       <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      if (ss_n) begin
        // Frame closed: abandon whatever was in flight.
        state    <= IDLE;
        tx_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: if (rx_valid) begin
            addr  <= rx_data[6:0];
            state <= rx_data[7] ? WR_DATA : RD_WAIT;
          end
          WR_DATA: if (rx_valid) begin
            if (in_range) begin
              wr_strobe <= 1'b1;
              wr_addr   <= addr;
            end else begin
              err <= 1'b1;
            end
            state <= DRAIN;
          end
          RD_WAIT: begin
            // Response is loaded once; tx_done is meaningless until it is offered.
            if (!tx_valid) begin
              tx_valid <= 1'b1;
              tx_data  <= rd_byte;
              if (!in_range) err <= 1'b1;
            end else if (tx_done) begin
              tx_valid <= 1'b0;
              state    <= DRAIN;
            end
          end
          DRAIN:   ;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_reg_bridge.sv
// Randomized frame-level bench for spi_reg_bridge against an array model.

module tb_spi_reg_bridge;
  localparam int         RC  = 8;
  localparam logic [7:0] ERR = 8'hEE;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_done;
  logic            ss_n;
  logic [8*RC-1:0] regs_flat;
  logic            wr_strobe;
  logic [6:0]      wr_addr;
  logic            err;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] mregs [RC];
  logic       merr;

  spi_reg_bridge #(.REG_COUNT(RC), .ERR_BYTE(ERR)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_done(tx_done), .ss_n(ss_n),
    .regs_flat(regs_flat), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8*RC-1:0] model_flat();
    logic [8*RC-1:0] f;
    for (int i = 0; i < RC; i++) f[8*i +: 8] = mregs[i];
    return f;
  endfunction

  function automatic logic [7:0] model_read(input logic [6:0] a);
    return (int'(a) < RC) ? mregs[a] : ERR;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < RC; i++) mregs[i] = 8'h00;
    merr = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic end_frame();
    ss_n = 1'b1;
    step();
    chk("frame_end_tx_valid", tx_valid, 0);
    step();
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d);
    bit ok;
    ok   = int'(a) < RC;
    ss_n = 1'b0;
    step();
    send_byte({1'b1, a});
    repeat ($urandom_range(0, 2)) step();
    send_byte(d);
    if (ok) mregs[a] = d;
    else    merr = 1'b1;
    chk("wr_strobe", wr_strobe, ok);
    if (ok) chk("wr_addr", wr_addr, a);
    chk("wr_regs", regs_flat, model_flat());
    chk("wr_err", err, merr);
    send_byte(8'($urandom));
    chk("wr_strobe_pulse", wr_strobe, 0);
    chk("drain_regs", regs_flat, model_flat());
    end_frame();
  endtask

  task automatic do_read(input logic [6:0] a, input bit early_done, input int hold);
    logic [7:0] exp;
    exp  = model_read(a);
    ss_n = 1'b0;
    step();
    send_byte({1'b0, a});
    chk("rd_not_yet_valid", tx_valid, 0);
    tx_done = early_done;
    step();
    tx_done = 1'b0;
    if (int'(a) >= RC) merr = 1'b1;
    chk("rd_tx_valid", tx_valid, 1);
    chk("rd_tx_data", tx_data, exp);
    chk("rd_err", err, merr);
    for (int k = 0; k < hold; k++) begin
      rx_data  = 8'($urandom);
      rx_valid = k[0];
      step();
      rx_valid = 1'b0;
      chk("rd_hold_valid", tx_valid, 1);
      chk("rd_hold_data", tx_data, exp);
    end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("rd_done_clears", tx_valid, 0);
    chk("rd_regs", regs_flat, model_flat());
    end_frame();
  endtask

  task automatic do_abort_write(input logic [6:0] a, input bit with_data);
    ss_n = 1'b0;
    step();
    send_byte({1'b1, a});
    ss_n = 1'b1;
    if (with_data) send_byte(8'($urandom));
    else           step();
    chk("abort_strobe", wr_strobe, 0);
    chk("abort_regs", regs_flat, model_flat());
    step();
  endtask

  initial begin
    rst_n = 1'b0; ss_n = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_done = 1'b0;
    model_reset();
    repeat (3) step();
    chk("rst_regs", regs_flat, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_wr_strobe", wr_strobe, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    step();

    // Directed scenarios
    do_write(7'd3, 8'h5A);
    chk("reg3", regs_flat[31:24], 8'h5A);
    do_read(7'd3, 1'b0, 3);
    do_abort_write(7'd2, 1'b0);
    do_abort_write(7'd2, 1'b1);
    do_write(7'd2, 8'hC3);
    do_write(7'd10, 8'h11);
    chk("oor_err", err, 1);
    do_read(7'd10, 1'b1, 1);

    // Bytes with ss_n high must not start a frame
    ss_n = 1'b1;
    send_byte(8'h85);
    send_byte(8'h77);
    chk("ssn_high_strobe", wr_strobe, 0);
    chk("ssn_high_regs", regs_flat, model_flat());

    // tx_done together with ss_n going high
    ss_n = 1'b0;
    step();
    send_byte(8'h02);
    step();
    ss_n = 1'b1; tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("done_and_ssn", tx_valid, 0);
    step();

    // Reset while a response is on offer acts without a clock edge
    ss_n = 1'b0;
    step();
    send_byte(8'h03);
    step();
    chk("pre_rst_valid", tx_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_valid", tx_valid, 0);
    chk("async_rst_regs", regs_flat, 0);
    chk("async_rst_err", err, 0);
    step();
    rst_n = 1'b1;
    ss_n  = 1'b1;
    step();

    // Randomized traffic
    for (int t = 0; t < 80; t++) begin
      logic [6:0] a;
      a = ($urandom_range(0, 5) == 0) ? 7'($urandom) : 7'($urandom_range(0, RC - 1));
      case ($urandom_range(0, 5))
        0, 1, 2: do_write(a, 8'($urandom));
        3, 4:    do_read(a, 1'($urandom), $urandom_range(0, 4));
        default: do_abort_write(a, 1'($urandom));
      endcase
    end
    chk("final_regs", regs_flat, model_flat());
    chk("final_err", err, merr);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
